// File: rtl/usb_tx_fifo_arbiter_if.sv
// rtl/usb_tx_fifo_arbiter_if.sv - requester and TX FIFO bus-write signal bundle
interface usb_tx_fifo_arbiter_if #(
  parameter int NUM_EP = 4
);
  logic [NUM_EP-1:0]    req;
  logic [NUM_EP-1:0]    reqFlush;
  logic [8*NUM_EP-1:0]  reqData;
  logic [16*NUM_EP-1:0] numElementsInFifo;
  logic [NUM_EP-1:0]    ack;
  logic [2:0]           address;
  logic                 writeEn;
  logic                 strobe_o;
  logic [NUM_EP-1:0]    fifoSelect;
  logic [7:0]           busDataOut;
  logic                 busy;

  // Requester / FIFO side: drives requests and fill levels, observes the bus
  modport master (
    output req, reqFlush, reqData, numElementsInFifo,
    input  ack, address, writeEn, strobe_o, fifoSelect, busDataOut, busy
  );

  // Arbiter side
  modport slave (
    input  req, reqFlush, reqData, numElementsInFifo,
    output ack, address, writeEn, strobe_o, fifoSelect, busDataOut, busy
  );
endinterface

// File: rtl/usb_tx_fifo_arbiter.sv
// rtl/usb_tx_fifo_arbiter.sv - round-robin scheduler for the shared TX FIFO bus-write port
module usb_tx_fifo_arbiter #(
  parameter int NUM_EP      = 4,
  parameter int FIFO_DEPTH  = 64,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                busClk,
  input  logic                rst,
  usb_tx_fifo_arbiter_if.slave bus
);
  localparam int IDXW  = $clog2(NUM_EP);
  localparam int HOLDW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [15:0]      DEPTH16   = 16'(FIFO_DEPTH);
  localparam logic [HOLDW-1:0] HOLD_INIT = HOLDW'(HOLD_CYCLES - 1);
  localparam logic [IDXW-1:0]  LAST_INIT = IDXW'(NUM_EP - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD} state_t;

  state_t            state;
  logic [HOLDW-1:0]  holdCnt;
  logic [IDXW-1:0]   lastGrant;
  logic [NUM_EP-1:0] full;
  logic [NUM_EP-1:0] elig;
  logic              found;
  logic [IDXW-1:0]   grantIdx;
  logic              grantFlush;
  logic [7:0]        grantData;
  int                cand;

  logic [NUM_EP-1:0] ackReg;
  logic [2:0]        addressReg;
  logic              writeEnReg;
  logic              strobeReg;
  logic [NUM_EP-1:0] fifoSelectReg;
  logic [7:0]        busDataReg;
  logic              busyReg;

  // Full/eligible flags: a flush is always eligible, a byte write needs room
  always_comb begin
    full = '0;
    elig = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      full[i] = bus.numElementsInFifo[16*i +: 16] >= DEPTH16;
      elig[i] = bus.req[i] & (bus.reqFlush[i] | ~full[i]);
    end
  end

  // Round-robin search starting just after the last granted requester
  always_comb begin
    found      = 1'b0;
    grantIdx   = '0;
    grantFlush = 1'b0;
    grantData  = 8'h00;
    cand       = 0;
    for (int k = 1; k <= NUM_EP; k++) begin
      cand = (int'(lastGrant) + k) % NUM_EP;
      if (!found && elig[IDXW'(cand)]) begin
        found    = 1'b1;
        grantIdx = IDXW'(cand);
      end
    end
    for (int i = 0; i < NUM_EP; i++) begin
      if (grantIdx == IDXW'(i)) begin
        grantFlush = bus.reqFlush[i];
        grantData  = bus.reqData[8*i +: 8];
      end
    end
  end

  // Grant FSM with registered bus outputs: one ISSUE cycle, then HOLD_CYCLES quiet cycles
  always_ff @(posedge busClk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      holdCnt       <= '0;
      lastGrant     <= LAST_INIT;
      ackReg        <= '0;
      addressReg    <= 3'b000;
      writeEnReg    <= 1'b0;
      strobeReg     <= 1'b0;
      fifoSelectReg <= '0;
      busDataReg    <= 8'h00;
      busyReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state         <= ISSUE;
            lastGrant     <= grantIdx;
            ackReg        <= NUM_EP'(1) << grantIdx;
            fifoSelectReg <= NUM_EP'(1) << grantIdx;
            writeEnReg    <= 1'b1;
            strobeReg     <= 1'b1;
            busyReg       <= 1'b1;
            addressReg    <= grantFlush ? 3'b100 : 3'b000;
            busDataReg    <= grantFlush ? 8'h01 : grantData;
          end
        end
        ISSUE: begin
          state         <= HOLD;
          holdCnt       <= HOLD_INIT;
          ackReg        <= '0;
          fifoSelectReg <= '0;
          writeEnReg    <= 1'b0;
          strobeReg     <= 1'b0;
          addressReg    <= 3'b000;
          busDataReg    <= 8'h00;
        end
        HOLD: begin
          if (holdCnt == '0) begin
            state   <= IDLE;
            busyReg <= 1'b0;
          end else begin
            holdCnt <= holdCnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack        = ackReg;
  assign bus.address    = addressReg;
  assign bus.writeEn    = writeEnReg;
  assign bus.strobe_o   = strobeReg;
  assign bus.fifoSelect = fifoSelectReg;
  assign bus.busDataOut = busDataReg;
  assign bus.busy       = busyReg;
endmodule
